encrypt_block_ctrl: RTL and testbench
=====================================

Name: encrypt_block_ctrl

Overview:
Block-level front end for the byte-serial `encrypt` core.
- Accepts one 128-bit plaintext block over a valid/ready handshake.
- Issues the core's one-cycle start (reset) pulse and streams the block in as 16 consecutive bytes, MSB byte first.
- Collects the 16 ciphertext bytes the core returns and presents them as one 128-bit result over a valid/ready handshake.
- Sits directly upstream of `encrypt` (drives its `input_data` and `rst`) and consumes its `output_data` and `output_ready`.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for the next ciphertext byte. Used only when ENC_TIMEOUT_EN is defined.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pt_data  in  128  plaintext block; byte 0 = bits [127:120].
- pt_valid  in  1  plaintext offered.
- pt_ready  out  1  block can accept plaintext.
- ct_data  out  128  ciphertext block; first received byte = bits [127:120].
- ct_valid  out  1  ciphertext available.
- ct_ready  in  1  consumer takes ciphertext.
- enc_rst  out  1  active-high start pulse to the core's `rst`.
- enc_in  out  8  byte to the core's `input_data`.
- enc_out  in  8  core's `output_data`.
- enc_out_ready  in  1  core's `output_ready`; qualifies enc_out.
- busy  out  1  high in every state except IDLE.
- err  out  1  timeout flag; tied 0 when ENC_TIMEOUT_EN is not defined.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, enc_rst=0, enc_in=8'h00, ct_data=0, ct_valid=0, pt_ready=1, busy=0, err=0, byte counter=0.
- States: IDLE -> START -> FEED -> COLLECT -> HOLD -> IDLE.
- IDLE:
  - pt_ready=1.
  - On pt_valid & pt_ready, register pt_data into the shift register and go to START.
- START:
  - enc_rst=1 for exactly one cycle.
  - pt_ready=0; it remains 0 until the block returns to IDLE.
  - Go to FEED with cnt=0.
- FEED:
  - enc_rst=0; enc_in = plaintext byte cnt, driven from a register.
  - The first byte appears in the same cycle enc_rst falls; 16 bytes are driven on 16 consecutive cycles with no gaps.
  - After cnt=15, go to COLLECT with cnt=0 and enc_in=8'h00.
  - enc_out_ready is ignored in FEED.
- COLLECT:
  - Each cycle with enc_out_ready=1: shift enc_out into ct_data from the MSB end and increment cnt.
  - Gaps (enc_out_ready=0) are allowed and do not reset cnt.
  - On the 16th capture, go to HOLD and assert ct_valid in the next cycle.
- HOLD:
  - ct_valid=1; ct_data stable.
  - On ct_ready, clear ct_valid and go to IDLE; pt_ready=1 from the next cycle.
  - enc_out_ready pulses in HOLD or IDLE (bytes beyond 16) are ignored.
- Latency: pt accepted at edge 0; enc_rst high in cycle 1; enc_in bytes in cycles 2..17; ct_valid rises 1 cycle after the 16th ciphertext byte is sampled.
- Throughput: one block in flight; no overlap between blocks.
- pt_valid while busy: no effect; pt_ready stays low.
- Reset mid-operation: immediate return to IDLE. Partial ciphertext is discarded and enc_rst drops to 0.
- cnt is 4 bits plus the state; it never wraps inside a state.

Optional Feature:
ENC_TIMEOUT_EN
- Defined:
  - In COLLECT, a counter increments each cycle with enc_out_ready=0 and clears on each captured byte.
  - If the counter reaches TIMEOUT_CYCLES, set err=1 (sticky until reset or the next accepted pt block), discard partial ciphertext, return to IDLE, and do not assert ct_valid.
- Not defined:
  - No timeout counter; COLLECT waits indefinitely.
  - err is constant 0.

Test Plan:
The bench uses a behavioural core stub: after enc_rst it samples 16 bytes, waits 10 cycles, then returns each byte XOR 8'hA5 on 16 consecutive cycles with output_ready=1.
- Basic block:
  - Stimulus: pt=128'h5c3532af37ddcb96a8936788e85a7109.
  - Required: enc_rst high in cycle 1 only; enc_in = 5c,35,32,af,...,71,09 in cycles 2..17; ct_data = pt ^ {16{8'hA5}}; ct_valid=1; busy=1 throughout.
- Backpressure:
  - Stimulus: hold ct_ready=0 for 20 cycles after ct_valid, then pulse it.
  - Required: ct_data stable; pt_ready=0 throughout; IDLE and pt_ready=1 one cycle after the pulse.
- Gapped output:
  - Stimulus: stub drops output_ready for 3 cycles after its 5th byte.
  - Required: ct_data is still correct; 17 extra output_ready pulses in HOLD do not alter ct_data.
- Back-to-back blocks:
  - Stimulus: second pt=128'h0111223344556677_8899aabbccddeeff offered with pt_valid held high.
  - Required: accepted the cycle after the first ct handshake; enc_in = 01,11,...,ff.
- Reset mid-FEED:
  - Stimulus: rst=0 asynchronously after the 6th byte.
  - Required: outputs immediately at reset values; a new block afterwards completes correctly.
- Timeout (ENC_TIMEOUT_EN, TIMEOUT_CYCLES=20):
  - Stimulus: stub stops after 8 bytes.
  - Required: err=1 after 20 idle cycles; ct_valid never asserted; pt_ready=1.

Source files
------------

// File: rtl/encrypt_block_ctrl.sv
// Purpose : 128-bit block front end for the byte-serial encrypt core (start pulse, byte feed, byte collect).
// Latency : enc_rst one cycle after pt accept, 16 feed bytes follow, ct_valid one cycle after the 16th ct byte.
// Backpr. : one block in flight; pt_ready low from accept until the ct handshake, ct held stable until ct_ready.
//
// Ports:
//   clk, rst             - rising-edge clock, asynchronous active-low reset
//   pt_data/valid/ready  - plaintext block in (byte 0 = bits [127:120])
//   ct_data/valid/ready  - ciphertext block out (first received byte = bits [127:120])
//   enc_rst, enc_in      - start pulse and input byte towards the core
//   enc_out, enc_out_ready - ciphertext byte from the core and its qualifier
//   busy, err            - not-idle indicator, sticky timeout flag
//
// Optional feature macro: ENC_TIMEOUT_EN (COLLECT timeout, drives err). When it is
// undefined, COLLECT waits indefinitely and err is tied low.

module encrypt_block_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] pt_data,
  input  logic         pt_valid,
  output logic         pt_ready,
  output logic [127:0] ct_data,
  output logic         ct_valid,
  input  logic         ct_ready,
  output logic         enc_rst,
  output logic [7:0]   enc_in,
  input  logic [7:0]   enc_out,
  input  logic         enc_out_ready,
  output logic         busy,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FEED,
    S_COLLECT,
    S_HOLD
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_cnt;
  logic [127:0] r_pt_sr;
  logic [127:0] r_ct;
  logic [7:0]   r_enc_in;
  logic         r_enc_rst;
  logic         r_ct_valid;

  logic w_accept;
  logic w_feed_last;
  logic w_capture;
  logic w_cap_last;
  logic w_ct_take;
  logic w_timeout;

  // The timeout counter must be able to hold TIMEOUT_CYCLES.
  if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
    $error("encrypt_block_ctrl: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  assign w_accept    = (r_state == S_IDLE) && pt_valid;
  assign w_feed_last = (r_state == S_FEED) && (r_cnt == 4'd15);
  assign w_capture   = (r_state == S_COLLECT) && enc_out_ready;
  assign w_cap_last  = w_capture && (r_cnt == 4'd15);
  // ct_valid is high for the whole of HOLD, so ct_ready alone completes the handshake there.
  assign w_ct_take   = (r_state == S_HOLD) && ct_ready;

`ifdef ENC_TIMEOUT_EN
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_err;

  // Fires on the idle cycle that brings the run of missing bytes to TIMEOUT_CYCLES.
  assign w_timeout = (r_state == S_COLLECT) && !enc_out_ready &&
                     (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
      if ((r_state != S_COLLECT) || enc_out_ready || w_timeout) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    pt_ready    = 1'b0;
    busy        = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        pt_ready = 1'b1;
        busy     = 1'b0;
        if (w_accept) w_state_nxt = S_START;
      end
      S_START: begin
        w_state_nxt = S_FEED;
      end
      S_FEED: begin
        if (w_feed_last) w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        if (w_cap_last) begin
          w_state_nxt = S_HOLD;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (w_ct_take) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: plaintext shifter, byte counter, ciphertext collector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= 4'd0;
      r_pt_sr    <= '0;
      r_ct       <= '0;
      r_enc_in   <= 8'h00;
      r_enc_rst  <= 1'b0;
      r_ct_valid <= 1'b0;
    end else begin
      // START lasts exactly one cycle, so the pulse is simply the registered accept.
      r_enc_rst <= w_accept;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) r_pt_sr <= pt_data;
        end
        S_START: begin
          // Byte 0 must be on enc_in the same cycle enc_rst falls.
          r_enc_in <= r_pt_sr[127:120];
          r_pt_sr  <= {r_pt_sr[119:0], 8'h00};
          r_cnt    <= 4'd0;
        end
        S_FEED: begin
          if (w_feed_last) begin
            r_enc_in <= 8'h00;
            r_cnt    <= 4'd0;
          end else begin
            r_enc_in <= r_pt_sr[127:120];
            r_pt_sr  <= {r_pt_sr[119:0], 8'h00};
            r_cnt    <= r_cnt + 4'd1;
          end
        end
        S_COLLECT: begin
          if (w_timeout) begin
            r_ct <= '0;
          end else if (w_capture) begin
            // Shift left so the first byte received ends up in bits [127:120].
            r_ct <= {r_ct[119:0], enc_out};
            if (w_cap_last) begin
              r_cnt      <= 4'd0;
              r_ct_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_HOLD: begin
          if (w_ct_take) r_ct_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign enc_rst  = r_enc_rst;
  assign enc_in   = r_enc_in;
  assign ct_data  = r_ct;
  assign ct_valid = r_ct_valid;

endmodule

// File: tb/tb_encrypt_block_ctrl.sv
// Bench for encrypt_block_ctrl with a behavioural stand-in for the encrypt core.
// The stand-in samples 16 bytes after enc_rst, waits 10 cycles, and returns each byte ^ 8'hA5.
// Expected ciphertext is computed directly as pt ^ {16{8'hA5}}.

module tb_encrypt_block_ctrl;

  localparam int TO_CYC = 20;
`ifdef ENC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [127:0] pt_data;
  logic         pt_valid;
  logic         pt_ready;
  logic [127:0] ct_data;
  logic         ct_valid;
  logic         ct_ready;
  logic         enc_rst;
  logic [7:0]   enc_in;
  logic [7:0]   enc_out;
  logic         enc_out_ready;
  logic         busy;
  logic         err;

  int checks = 0;
  int errors = 0;

  // Core stand-in configuration
  int cfg_gap_after  = 0;   // byte count after which output pauses (0 = never)
  int cfg_gap_len    = 3;
  int cfg_stop_after = 16;  // bytes returned before going silent
  int cfg_extra      = 0;   // spurious output_ready pulses after the 16th byte

  encrypt_block_ctrl #(
    .TIMEOUT_CYCLES(TO_CYC),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pt_data(pt_data),
    .pt_valid(pt_valid),
    .pt_ready(pt_ready),
    .ct_data(ct_data),
    .ct_valid(ct_valid),
    .ct_ready(ct_ready),
    .enc_rst(enc_rst),
    .enc_in(enc_in),
    .enc_out(enc_out),
    .enc_out_ready(enc_out_ready),
    .busy(busy),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core stand-in: acts 2 time units after each rising edge.
  initial begin : core_stub
    logic [7:0] sbytes [16];
    int ph, sidx, swait, sgap, sextra;
    ph = 0; sidx = 0; swait = 0; sgap = 0; sextra = 0;
    enc_out = 8'h00;
    enc_out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      enc_out_ready = 1'b0;
      enc_out = 8'($urandom);
      if (!rst) begin
        ph = 0;
      end else begin
        case (ph)
          0: if (enc_rst === 1'b1) begin ph = 1; sidx = 0; end
          1: begin
            sbytes[sidx] = enc_in;
            sidx++;
            if (sidx == 16) begin ph = 2; swait = 0; end
          end
          2: begin
            swait++;
            if (swait == 10) begin ph = 3; sidx = 0; sgap = 0; end
          end
          3: begin
            if (sgap > 0) begin
              sgap--;
            end else if (sidx < cfg_stop_after) begin
              enc_out = sbytes[sidx] ^ 8'hA5;
              enc_out_ready = 1'b1;
              sidx++;
              if (sidx == cfg_gap_after) sgap = cfg_gap_len;
              if (sidx == 16) begin ph = 4; sextra = cfg_extra; end
            end else begin
              ph = 0;
            end
          end
          default: begin
            if (sextra > 0) begin
              enc_out_ready = 1'b1;
              sextra--;
            end else begin
              ph = 0;
            end
          end
        endcase
      end
    end
  end

  // Drives one block end to end, checking every cycle against the expected timeline.
  // Entered and left at a falling edge. Returns whether the block ended in a timeout.
  task automatic run_block(input logic [127:0] pt, input int hold, input bit keep_valid,
                           input logic [127:0] next_pt, output bit timed);
    logic [127:0] exp_ct;
    int caps, idle;
    bit done;
    exp_ct = pt ^ {16{8'hA5}};
    timed = 1'b0;
    pt_data = pt;
    pt_valid = 1'b1;
    checks++;
    if (pt_ready !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL offer: pt_ready=%b busy=%b required 1 0", pt_ready, busy); end
    @(negedge clk);
    checks++;
    if (enc_rst !== 1'b1 || busy !== 1'b1 || pt_ready !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL start: enc_rst=%b busy=%b pt_ready=%b err=%b required 1 1 0 0", enc_rst, busy, pt_ready, err);
    end
    if (keep_valid) pt_data = next_pt; else pt_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (enc_rst !== 1'b0 || enc_in !== pt[127-8*i -: 8] || pt_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL feed[%0d]: enc_rst=%b enc_in=%h pt_ready=%b busy=%b required 0 %h 0 1",
                 i, enc_rst, enc_in, pt_ready, busy, pt[127-8*i -: 8]);
      end
    end
    caps = 0; idle = 0; done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (caps == 16) begin
        checks++;
        if (ct_valid !== 1'b1 || ct_data !== exp_ct || busy !== 1'b1 || pt_ready !== 1'b0) begin
          errors++;
          $display("FAIL ct_rise: ct_valid=%b ct_data=%h busy=%b pt_ready=%b required 1 %h 1 0",
                   ct_valid, ct_data, busy, pt_ready, exp_ct);
        end
        done = 1'b1;
      end else if (TO_EN && idle >= TO_CYC) begin
        checks++;
        if (err !== 1'b1 || ct_valid !== 1'b0 || pt_ready !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL timeout_hit: err=%b ct_valid=%b pt_ready=%b busy=%b required 1 0 1 0",
                   err, ct_valid, pt_ready, busy);
        end
        done = 1'b1;
        timed = 1'b1;
      end else begin
        checks++;
        if (ct_valid !== 1'b0 || err !== 1'b0 || enc_in !== 8'h00 || pt_ready !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL collect: ct_valid=%b err=%b enc_in=%h pt_ready=%b busy=%b required 0 0 00 0 1 (caps=%0d)",
                   ct_valid, err, enc_in, pt_ready, busy, caps);
        end
        if (enc_out_ready === 1'b1) begin caps++; idle = 0; end
        else idle++;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL ct_wait: no ct_valid within 200 cycles, captures=%0d required 16", caps);
    end
    if (done && !timed) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checks++;
        if (ct_valid !== 1'b1 || ct_data !== exp_ct || pt_ready !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL hold[%0d]: ct_valid=%b ct_data=%h pt_ready=%b required 1 %h 0",
                   h, ct_valid, ct_data, pt_ready, exp_ct);
        end
      end
      ct_ready = 1'b1;
      @(negedge clk);
      ct_ready = 1'b0;
      checks++;
      if (ct_valid !== 1'b0 || pt_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL release: ct_valid=%b pt_ready=%b busy=%b required 0 1 0", ct_valid, pt_ready, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({pt_ready, busy, enc_rst, ct_valid, err, enc_in, ct_data} !== {5'b10000, 8'h00, 128'h0}) begin
      errors++;
      $display("FAIL reset: rdy/busy/rst/vld/err=%b%b%b%b%b enc_in=%h ct=%h required 10000 00 0",
               pt_ready, busy, enc_rst, ct_valid, err, enc_in, ct_data);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (pt_ready !== 1'b1 || busy !== 1'b0 || enc_rst !== 1'b0)
      begin errors++; $display("FAIL post_reset: pt_ready=%b busy=%b enc_rst=%b required 1 0 0", pt_ready, busy, enc_rst); end
  endtask

  task automatic test_basic();
    bit t;
    run_block(128'h5c3532af37ddcb96a8936788e85a7109, 3, 1'b0, 128'h0, t);
  endtask

  task automatic test_backpressure();
    bit t;
    run_block({$urandom, $urandom, $urandom, $urandom}, 20, 1'b0, 128'h0, t);
  endtask

  task automatic test_gapped();
    bit t;
    cfg_gap_after = 5;
    cfg_gap_len = 3;
    cfg_extra = 17;
    run_block({$urandom, $urandom, $urandom, $urandom}, 25, 1'b0, 128'h0, t);
    cfg_gap_after = 0;
    cfg_extra = 0;
  endtask

  task automatic test_back_to_back();
    bit t;
    logic [127:0] second;
    second = 128'h0111223344556677_8899aabbccddeeff;
    run_block({$urandom, $urandom, $urandom, $urandom}, 2, 1'b1, second, t);
    run_block(second, 2, 1'b0, 128'h0, t);
  endtask

  task automatic test_reset_mid_feed();
    bit t;
    logic [127:0] pt;
    pt = {$urandom, $urandom, $urandom, $urandom};
    pt_data = pt;
    pt_valid = 1'b1;
    @(negedge clk);
    pt_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (enc_in !== pt[127-8*i -: 8])
        begin errors++; $display("FAIL rst_feed[%0d]: enc_in=%h required %h", i, enc_in, pt[127-8*i -: 8]); end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({pt_ready, busy, enc_rst, ct_valid, err, enc_in, ct_data} !== {5'b10000, 8'h00, 128'h0}) begin
      errors++;
      $display("FAIL mid_reset: rdy/busy/rst/vld/err=%b%b%b%b%b enc_in=%h ct=%h required 10000 00 0",
               pt_ready, busy, enc_rst, ct_valid, err, enc_in, ct_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_block({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0, 128'h0, t);
  endtask

  task automatic test_random();
    bit t;
    for (int n = 0; n < 6; n++) begin
      cfg_gap_after = $urandom_range(0, 15);
      cfg_gap_len = $urandom_range(1, 4);
      run_block({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 4), 1'b0, 128'h0, t);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    cfg_gap_after = 0;
    cfg_gap_len = 3;
  endtask

`ifdef ENC_TIMEOUT_EN
  task automatic test_timeout();
    bit t;
    cfg_stop_after = 8;
    run_block({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 128'h0, t);
    cfg_stop_after = 16;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || ct_valid !== 1'b0 || pt_ready !== 1'b1) begin
        errors++;
        $display("FAIL timeout_sticky: err=%b ct_valid=%b pt_ready=%b required 1 0 1", err, ct_valid, pt_ready);
      end
    end
    run_block({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0, 128'h0, t);
  endtask
`endif

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin : main
    rst = 1'b1;
    pt_valid = 1'b0;
    pt_data = '0;
    ct_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_back_to_back();
    test_reset_mid_feed();
    test_random();
`ifdef ENC_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
